// File: rtl/alif_pkg.sv
// alif_pkg: shared state encoding, field widths and frame packing for the ALIF parameter sequencer.
package alif_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, SHIFT, RELEASE, WAIT_READY} state_t;
  localparam int WA_W = 3;
  localparam int LR_W = 8;
  localparam int TM_W = 8;
  localparam int LC_W = 4;
  localparam int FRAME_LEN = 32;
  localparam int HEADER_LEN = 1;
  localparam int CNT_W = $clog2(FRAME_LEN);
  function automatic logic [FRAME_LEN-1:0] pack_frame(
    input logic [WA_W-1:0] wa,
    input logic [LR_W-1:0] lr,
    input logic [TM_W-1:0] tm,
    input logic [LC_W-1:0] lc
  );
    return {5'b0, wa, lr, tm, 4'b0, lc};
  endfunction
endpackage

// File: rtl/alif_frame_shifter.sv
// alif_frame_shifter: parallel-load MSB-first shift register driving the registered serial bit.
// The bit counter holds the index of the bit on data; it wraps 0->31 on the header shift.
module alif_frame_shifter
  import alif_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic [FRAME_LEN-1:0] frame,
  input  logic                 shift,
  input  logic                 clear,
  output logic                 data,
  output logic                 last
);
  logic [FRAME_LEN-1:0] sr;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sr <= '0;
      cnt <= '0;
      data <= 1'b0;
    end else if (enable) begin
      if (load) begin
        sr <= frame;
        cnt <= '0;
        data <= 1'b0;
      end else if (shift) begin
        data <= sr[FRAME_LEN-1];
        sr <= {sr[FRAME_LEN-2:0], 1'b0};
        cnt <= cnt - 1'b1;
      end else if (clear) begin
        data <= 1'b0;
      end
    end
  assign last = cnt == '0;
endmodule

// File: rtl/alif_param_sequencer.sv
// alif_param_sequencer: valid/ready to serial framing for the ALIF parameter loader.
// Define ALIF_SEQ_VERIFY_EN to add read-back verification of the loaded parameters.
module alif_param_sequencer
  import alif_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [WA_W-1:0] cfg_weight_a,
  input  logic [LR_W-1:0] cfg_leak_rate,
  input  logic [TM_W-1:0] cfg_threshold_min,
  input  logic [LC_W-1:0] cfg_leak_cycles,
  output logic            ser_load_enable,
  output logic            ser_data,
  input  logic            loader_params_ready,
  output logic            busy,
  output logic            done,
  output logic            frame_error
`ifdef ALIF_SEQ_VERIFY_EN
  ,
  input  logic [WA_W-1:0] rb_weight_a,
  input  logic [LR_W-1:0] rb_leak_rate,
  input  logic [TM_W-1:0] rb_threshold_min,
  input  logic [LC_W-1:0] rb_leak_cycles,
  output logic            verify_error
`endif
);
  localparam int CNT_MAX = GAP_CYCLES > TIMEOUT ? GAP_CYCLES : TIMEOUT;
  localparam int TW = $clog2(CNT_MAX + 1);
  state_t state, state_d;
  logic [TW-1:0] cnt, cnt_d;
  logic ready_d, sle_d, busy_d, done_d, err_d;
  logic load, shift, clear, last, mismatch;
  logic [FRAME_LEN-1:0] frame;
  assign frame = pack_frame(cfg_weight_a, cfg_leak_rate, cfg_threshold_min, cfg_leak_cycles);
  alif_frame_shifter u_shifter (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .load(load),
    .frame(frame),
    .shift(shift),
    .clear(clear),
    .data(ser_data),
    .last(last)
  );
`ifdef ALIF_SEQ_VERIFY_EN
  logic [WA_W-1:0] wa_q;
  logic [LR_W-1:0] lr_q;
  logic [TM_W-1:0] tm_q;
  logic [LC_W-1:0] lc_q;
  assign mismatch = {rb_weight_a, rb_leak_rate, rb_threshold_min, rb_leak_cycles} != {wa_q, lr_q, tm_q, lc_q};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wa_q <= '0;
      lr_q <= '0;
      tm_q <= '0;
      lc_q <= '0;
      verify_error <= 1'b0;
    end else if (enable) begin
      if (load) begin
        wa_q <= cfg_weight_a;
        lr_q <= cfg_leak_rate;
        tm_q <= cfg_threshold_min;
        lc_q <= cfg_leak_cycles;
        verify_error <= 1'b0;
      end else if (state == WAIT_READY && loader_params_ready) begin
        verify_error <= mismatch;
      end
    end
`else
  assign mismatch = 1'b0;
`endif
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    ready_d = cfg_ready;
    sle_d = ser_load_enable;
    busy_d = busy;
    done_d = 1'b0;
    err_d = frame_error;
    load = 1'b0;
    shift = 1'b0;
    clear = 1'b0;
    case (state)
      IDLE: if (cfg_valid) begin
        load = 1'b1;
        err_d = 1'b0;
        ready_d = 1'b0;
        busy_d = 1'b1;
        sle_d = 1'b1;
        state_d = HEADER;
      end
      HEADER: begin
        shift = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (last) begin
        clear = 1'b1;
        sle_d = 1'b0;
        state_d = RELEASE;
      end else begin
        shift = 1'b1;
      end
      RELEASE: begin
        cnt_d = cnt == TW'(GAP_CYCLES - 1) ? '0 : cnt + 1'b1;
        state_d = cnt == TW'(GAP_CYCLES - 1) ? WAIT_READY : RELEASE;
      end
      WAIT_READY: if (loader_params_ready || cnt == TW'(TIMEOUT - 1)) begin
        done_d = 1'b1;
        err_d = !loader_params_ready || mismatch;
        busy_d = 1'b0;
        ready_d = 1'b1;
        cnt_d = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      cfg_ready <= 1'b1;
      ser_load_enable <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      frame_error <= 1'b0;
    end else if (enable) begin
      state <= state_d;
      cnt <= cnt_d;
      cfg_ready <= ready_d;
      ser_load_enable <= sle_d;
      busy <= busy_d;
      done <= done_d;
      frame_error <= err_d;
    end
endmodule
